// File: rtl/uart_mmio_fifo.sv
// 8N1 serial peripheral for the MMIO serial window.
// Has a data/status register pair, with TX and RX byte FIFOs between the CPU side and the line.

module uart_mmio_fifo_buf #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata_c,
  output logic         empty_c,
  output logic         full_c
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_push, do_pop;

  assign empty_c = (wr_ptr_q == rd_ptr_q);
  assign full_c  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata_c = mem_q[rd_ptr_q[AW-1:0]];
  assign do_pop  = pop & ~empty_c;
  // A pop frees the slot this cycle, so a push into a full FIFO still lands.
  assign do_push = push & (~full_c | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end
endmodule

module uart_mmio_fifo #(
  parameter int unsigned CLK_FREQ   = 60000000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        acc_en,
  input  logic        acc_we,
  input  logic        acc_reg,
  input  logic [7:0]  acc_wdata,
  output logic [31:0] acc_rdata,
  output logic        txd,
  input  logic        rxd
);
  localparam int unsigned DIV = CLK_FREQ / BAUD;
  localparam int unsigned CW  = $clog2(DIV + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_e;

  tx_state_e   tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        txd_q, txd_d;

  rx_state_e   rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic        rx_meta_q, rx_meta_d;
  logic        rxs_q, rxs_d;
  logic        rxs_prev_q, rxs_prev_d;

  logic [31:0] acc_rdata_q, acc_rdata_d;
  logic        ovf_q, ovf_d;

  logic        wr_data_c, rd_data_c, rd_stat_c;
  logic        tx_pop_c, tx_empty_c, tx_full_c;
  logic [7:0]  tx_head_c;
  logic        rx_push_req_c, rx_push_c, rx_ovf_c, rx_pop_c, rx_empty_c, rx_full_c;
  logic [7:0]  rx_head_c;
  logic [31:0] status_c;

  assign wr_data_c = acc_en &  acc_we & ~acc_reg;
  assign rd_data_c = acc_en & ~acc_we & ~acc_reg;
  assign rd_stat_c = acc_en & ~acc_we &  acc_reg;
  assign rx_pop_c  = rd_data_c & ~rx_empty_c;
  assign rx_push_c = rx_push_req_c & (~rx_full_c | rx_pop_c);
  assign rx_ovf_c  = rx_push_req_c & rx_full_c & ~rx_pop_c;
  assign status_c  = {29'b0, ovf_q, ~rx_empty_c, ~tx_full_c};
  assign acc_rdata = acc_rdata_q;
  assign txd       = txd_q;

  uart_mmio_fifo_buf #(.DEPTH(FIFO_DEPTH), .W(8)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(wr_data_c), .wdata(acc_wdata), .pop(tx_pop_c),
    .rdata_c(tx_head_c), .empty_c(tx_empty_c), .full_c(tx_full_c)
  );

  uart_mmio_fifo_buf #(.DEPTH(FIFO_DEPTH), .W(8)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push_c), .wdata(rx_shift_q), .pop(rx_pop_c),
    .rdata_c(rx_head_c), .empty_c(rx_empty_c), .full_c(rx_full_c)
  );

  // CPU register reads; an overflow in the same cycle outranks the status-read clear
  always_comb begin
    acc_rdata_d = acc_rdata_q;
    ovf_d       = ovf_q;
    if (rd_data_c) acc_rdata_d = rx_empty_c ? 32'h0 : {24'b0, rx_head_c};
    if (rd_stat_c) begin
      acc_rdata_d = status_c;
      ovf_d       = 1'b0;
    end
    if (rx_ovf_c) ovf_d = 1'b1;
  end

  // TX framer
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    txd_d      = txd_q;
    tx_pop_c   = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        txd_d = 1'b1;
        if (!tx_empty_c) begin
          tx_pop_c   = 1'b1;
          tx_shift_d = tx_head_c;
          txd_d      = 1'b0;
          tx_cnt_d   = CNT_FULL;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt_q == '0) begin
          tx_state_d = TX_DATA;
          tx_cnt_d   = CNT_FULL;
          tx_bit_d   = 3'd0;
          txd_d      = tx_shift_q[0];
        end else tx_cnt_d = tx_cnt_q - CW'(1);
      end
      TX_DATA: begin
        if (tx_cnt_q == '0) begin
          tx_cnt_d = CNT_FULL;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = TX_STOP;
            txd_d      = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            txd_d      = tx_shift_q[1];
          end
        end else tx_cnt_d = tx_cnt_q - CW'(1);
      end
      TX_STOP: begin
        if (tx_cnt_q == '0) tx_state_d = TX_IDLE;
        else                tx_cnt_d   = tx_cnt_q - CW'(1);
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // RX deframer, run on the synchronised line rxs_q
  always_comb begin
    rx_meta_d     = rxd;
    rxs_d         = rx_meta_q;
    rxs_prev_d    = rxs_q;
    rx_state_d    = rx_state_q;
    rx_cnt_d      = rx_cnt_q;
    rx_bit_d      = rx_bit_q;
    rx_shift_d    = rx_shift_q;
    rx_push_req_c = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rxs_prev_q && !rxs_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = CNT_HALF;
        end
      end
      RX_START: begin
        if (rx_cnt_q == '0) begin
          rx_state_d = rxs_q ? RX_IDLE : RX_DATA;
          rx_cnt_d   = CNT_FULL;
          rx_bit_d   = 3'd0;
        end else rx_cnt_d = rx_cnt_q - CW'(1);
      end
      RX_DATA: begin
        if (rx_cnt_q == '0) begin
          rx_shift_d = {rxs_q, rx_shift_q[7:1]};
          rx_cnt_d   = CNT_FULL;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else rx_cnt_d = rx_cnt_q - CW'(1);
      end
      RX_STOP: begin
        if (rx_cnt_q == '0) begin
          if (rxs_q) begin
            rx_push_req_c = 1'b1;
            rx_state_d    = RX_IDLE;
          end else rx_state_d = RX_BREAK;
        end else rx_cnt_d = rx_cnt_q - CW'(1);
      end
      RX_BREAK: begin
        if (rxs_q) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_state_q  <= TX_IDLE;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_shift_q  <= '0;
      txd_q       <= 1'b1;
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      rx_meta_q   <= 1'b1;
      rxs_q       <= 1'b1;
      rxs_prev_q  <= 1'b1;
      acc_rdata_q <= '0;
      ovf_q       <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      txd_q       <= txd_d;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      rx_meta_q   <= rx_meta_d;
      rxs_q       <= rxs_d;
      rxs_prev_q  <= rxs_prev_d;
      acc_rdata_q <= acc_rdata_d;
      ovf_q       <= ovf_d;
    end
  end
endmodule

// File: tb/tb_uart_mmio_fifo.sv
// Directed bench for uart_mmio_fifo at DIV=16.
// Covers reset, TX framing, RX, FIFO full/overflow, framing error and reset mid-frame.

module tb_uart_mmio_fifo;
  localparam int unsigned DIV = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        acc_en, acc_we, acc_reg;
  logic [7:0]  acc_wdata;
  logic [31:0] acc_rdata;
  logic        txd;
  logic        rxd;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  uart_mmio_fifo #(.CLK_FREQ(160), .BAUD(10), .FIFO_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .acc_en(acc_en), .acc_we(acc_we), .acc_reg(acc_reg),
    .acc_wdata(acc_wdata), .acc_rdata(acc_rdata), .txd(txd), .rxd(rxd)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic sel, input logic [7:0] data);
    acc_en = 1'b1; acc_we = 1'b1; acc_reg = sel; acc_wdata = data;
    tick();
    acc_en = 1'b0; acc_we = 1'b0;
  endtask

  task automatic bus_read(input logic sel, output logic [31:0] data);
    acc_en = 1'b1; acc_we = 1'b0; acc_reg = sel;
    tick();
    acc_en = 1'b0;
    data = acc_rdata;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = fr[i];
      tick(DIV);
    end
    rxd = 1'b1;
  endtask

  // Samples txd once per bit period, starting at frame bit first_idx.
  task automatic decode_tx(input int first_idx, output logic [9:0] fr);
    fr = '0;
    for (int i = 0; i < 10; i++) begin
      if (i >= first_idx) begin
        fr[i] = txd;
        if (i < 9) tick(DIV);
      end
    end
  endtask

  task automatic wait_fall(output logic ok);
    int n;
    n = 0;
    while (txd !== 1'b0 && n < 400) begin
      tick();
      n++;
    end
    ok = (txd === 1'b0);
  endtask

  initial begin
    logic [31:0] rd;
    logic [9:0]  fr;
    logic [9:0]  t2_exp;
    logic [9:0]  t6_fr;
    logic        ok;
    logic        seen_low;

    rst = 1'b0; acc_en = 1'b0; acc_we = 1'b0; acc_reg = 1'b0;
    acc_wdata = 8'h00; rxd = 1'b1;

    // T1 reset
    tick(3);
    check("t1_txd", {31'b0, txd}, 32'h1);
    check("t1_rdata", acc_rdata, 32'h0);
    rst = 1'b1;
    tick(4);
    bus_read(1'b1, rd);
    check("t1_status", rd, 32'h1);
    bus_read(1'b0, rd);
    check("t1_empty_data_read", rd, 32'h0);

    // T2 single TX frame of 8'hA5
    t2_exp = {1'b1, 8'hA5, 1'b0};
    bus_write(1'b0, 8'hA5);
    check("t2_txd_before", {31'b0, txd}, 32'h1);
    tick();
    check("t2_txd_fall", {31'b0, txd}, 32'h0);
    tick(7);
    decode_tx(0, fr);
    for (int i = 0; i < 10; i++)
      check($sformatf("t2_bit%0d", i), {31'b0, fr[i]}, {31'b0, t2_exp[i]});
    tick(20);
    check("t2_idle_high", {31'b0, txd}, 32'h1);

    // T3 single RX frame of 8'h3C
    send_rx(8'h3C, 1'b1);
    bus_read(1'b1, rd);
    check("t3_status_avail", rd, 32'h3);
    bus_read(1'b0, rd);
    check("t3_data", rd, 32'h3C);
    bus_read(1'b1, rd);
    check("t3_status_after", rd, 32'h1);

    // T4 TX flood: 18 writes, one goes in flight, 16 fill the FIFO, the last drops
    acc_en = 1'b1; acc_we = 1'b1; acc_reg = 1'b0;
    for (int k = 0; k < 18; k++) begin
      acc_wdata = 8'h40 + 8'(k);
      tick();
    end
    acc_en = 1'b0; acc_we = 1'b0;
    bus_read(1'b1, rd);
    check("t4_status_full", rd, 32'h0);
    tick(6);
    decode_tx(1, fr);
    check("t4_byte0", {24'b0, fr[8:1]}, 32'h40);
    check("t4_stop0", {31'b0, fr[9]}, 32'h1);
    for (int k = 1; k < 17; k++) begin
      wait_fall(ok);
      check($sformatf("t4_fall%0d", k), {31'b0, ok}, 32'h1);
      tick(DIV / 2);
      decode_tx(0, fr);
      check($sformatf("t4_byte%0d", k), {24'b0, fr[8:1]}, 32'h40 + k);
      check($sformatf("t4_frame%0d", k), {30'b0, fr[9], fr[0]}, 32'h2);
    end
    wait_fall(ok);
    check("t4_no_extra_frame", {31'b0, ok}, 32'h0);
    bus_read(1'b1, rd);
    check("t4_status_drained", rd, 32'h1);

    // T5 RX overflow, then framing error
    for (int k = 0; k < 17; k++) send_rx(8'h10 + 8'(k), 1'b1);
    bus_read(1'b1, rd);
    check("t5_status_ovf", rd, 32'h7);
    bus_read(1'b1, rd);
    check("t5_status_ovf_cleared", rd, 32'h3);
    for (int k = 0; k < 16; k++) begin
      bus_read(1'b0, rd);
      check($sformatf("t5_data%0d", k), rd, 32'h10 + k);
    end
    bus_read(1'b1, rd);
    check("t5_status_drained", rd, 32'h1);
    send_rx(8'hE7, 1'b0);
    tick(4);
    bus_read(1'b1, rd);
    check("t5_framing_no_push", rd, 32'h1);
    send_rx(8'h81, 1'b1);
    bus_read(1'b0, rd);
    check("t5_recover_data", rd, 32'h81);

    // T6 reset during TX data bit 4 and RX data bit 4
    bus_write(1'b0, 8'h5A);
    bus_write(1'b0, 8'h77);
    t6_fr = {1'b1, 8'hC3, 1'b0};
    for (int c = 0; c < 10 * DIV; c++) begin
      rxd = t6_fr[c / DIV];
      if (c == 88) rst = 1'b0;
      tick();
      if (c == 88) check("t6_txd_after_rst", {31'b0, txd}, 32'h1);
    end
    rxd = 1'b1;
    rst = 1'b1;
    seen_low = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (txd !== 1'b1) seen_low = 1'b1;
      tick();
    end
    check("t6_tx_quiet", {31'b0, seen_low}, 32'h0);
    bus_read(1'b1, rd);
    check("t6_status", rd, 32'h1);
    bus_read(1'b0, rd);
    check("t6_no_rx_byte", rd, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
